uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//  Transmit side of the SoC console UART: 8N1 serializer fed by a byte FIFO, drives uart_tx_out
//  (PMOD_B4) toward the host USB/UART Rx. CPU/IO-bus write path pushes bytes, block shifts them
//  out LSB-first at a fixed baud derived from the 48 MHz system clock. Counterpart of the UART
//  receiver on uart_rx_in; shares its CLK_FREQ/BAUD parameters so both ends agree on bit timing.
// PARAMETERS
//  CLK_FREQ    48_000_000  system clock in Hz
//  BAUD        115_200     line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (truncated, 416 @ default)
//  FIFO_DEPTH  16          byte FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1   system clock (48 MHz), all logic on rising edge
//  reset_n      in   1   asynchronous active-low reset
//  wr_data      in   8   byte to transmit
//  wr_en        in   1   push wr_data this cycle (accepted only when full==0)
//  clr_overrun  in   1   clears overrun flag
//  full         out  1   FIFO holds FIFO_DEPTH bytes
//  empty        out  1   FIFO holds 0 bytes
//  level        out  $clog2(FIFO_DEPTH)+1  bytes currently in FIFO (0..FIFO_DEPTH)
//  busy         out  1   serializer not in IDLE (frame in progress)
//  overrun      out  1   sticky: a write was attempted while full
//  tx_out       out  1   serial line, idles high
// BEHAVIOUR
//  Reset (async assert, sync-released use): tx_out=1, busy=0, empty=1, full=0, level=0,
//   overrun=0, FSM=IDLE, FIFO pointers/bit counters=0. Reset mid-frame aborts; line returns high.
//  FIFO: push when wr_en&&!full; write when full is dropped (contents untouched) and sets overrun.
//   Push while full is rejected even if a pop occurs same cycle. Push+pop same cycle with
//   0<level<DEPTH: level unchanged. Pointers wrap mod FIFO_DEPTH. full/empty/level registered,
//   reflect pushes/pops on the edge that performs them.
//  overrun: set on rejected write; clr_overrun clears; set wins if both same cycle.
//  Baud counter: counts 0..CLKS_PER_BIT-1 within each bit; every bit lasts exactly CLKS_PER_BIT clocks.
//  FSM (registered tx_out):
//   IDLE : tx_out=1. If !empty: pop head into shift reg, tx_out<=0, ->START.
//   START: hold 0 for CLKS_PER_BIT, then tx_out<=bit0, ->DATA.
//   DATA : 8 bits LSB-first, CLKS_PER_BIT each; after bit7 tx_out<=1, ->STOP.
//   STOP : hold 1 for CLKS_PER_BIT; at end, if !empty pop and start next frame immediately
//          (tx_out<=0, ->START, no idle gap), else ->IDLE.
//  Latency: byte pushed at edge E0 into empty FIFO with FSM IDLE -> tx_out low after edge E1.
//  Frame = 10*CLKS_PER_BIT clocks start-edge to start-edge when back-to-back.
//  busy=1 in START/DATA/STOP. Popped byte already gone from FIFO (level drops at pop edge).
//  wr_data may change any time after the accepting edge; frame uses the FIFO copy.
// TESTING (bench uses CLK_FREQ=1_000_000, BAUD=100_000 -> 10 clk/bit, FIFO_DEPTH=4)
//  reset_n low mid-frame -> tx_out=1, busy=0, empty=1, level=0 immediately (async).
//  push 8'hA5 when idle -> tx_out low 1 clk later; bits 1,0,1,0,0,1,0,1 each 10 clk; stop 10 clk; busy drops.
//  push 8'h00,8'hFF,8'h55 consecutive cycles -> three frames, 100 clk apart, no high gap between stop/start.
//  push 5 bytes while first frame running -> level reaches 4, full=1, 5th dropped, overrun=1;
//   clr_overrun -> overrun=0; exactly 5 frames sent only if 5th push found space, else 4.
//  push at same edge as STOP-end pop with level=4 -> push rejected, overrun=1, level=3.
//  with level=2 push+pop same edge -> level stays 2, FIFO order preserved in output bytes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: transmit half of the console UART.
// A byte FIFO feeds an 8N1 serializer that shifts bytes out LSB-first
// at CLKS_PER_BIT = CLK_FREQ/BAUD system clocks per bit.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   wr_data, wr_en        byte push (accepted when full == 0)
//   clr_overrun           clears the sticky overrun flag
//   full, empty, level    registered FIFO status
//   busy                  serializer frame in progress
//   overrun               sticky: a write was dropped because the FIFO was full
//   tx_out                serial line, idles high
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 48_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_en,
    input  logic                          clr_overrun,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          busy,
    output logic                          overrun,
    output logic                          tx_out
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W        = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // FIFO storage and status
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovr_q, ovr_d;

    // Serializer
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;

    logic             push_c;
    logic             pop_c;
    logic             cnt_last_c;
    logic [7:0]       head_c;

    assign push_c     = wr_en && !full_q;
    assign cnt_last_c = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign head_c     = mem_q[rd_ptr_q];

    // FIFO pointer / level / flag next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovr_d    = ovr_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == LVL_W'(FIFO_DEPTH));
        empty_d = (level_d == LVL_W'(0));
        // A rejected write outranks a simultaneous clear.
        if (wr_en && full_q) begin
            ovr_d = 1'b1;
        end else if (clr_overrun) begin
            ovr_d = 1'b0;
        end
    end

    // Serializer next-state and outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_c   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = CNT_W'(0);
                tx_d  = 1'b1;
                if (!empty_q) begin
                    pop_c   = 1'b1;
                    shift_d = head_c;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_last_c) begin
                    cnt_d   = CNT_W'(0);
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_last_c) begin
                    cnt_d = CNT_W'(0);
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        // Shift so the next bit to send is always at bit 0.
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (cnt_last_c) begin
                    cnt_d = CNT_W'(0);
                    if (!empty_q) begin
                        // Back-to-back frame: no idle cycle between stop and start.
                        pop_c   = 1'b1;
                        shift_d = head_c;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = CNT_W'(0);
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovr_q    <= 1'b0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovr_q    <= ovr_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO data array; contents need no reset
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;
    assign busy    = busy_q;
    assign overrun = ovr_q;
    assign tx_out  = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 10 clocks per bit, 4-entry FIFO.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       clr_overrun;
    logic       full;
    logic       empty;
    logic [2:0] level;
    logic       busy;
    logic       overrun;
    logic       tx_out;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    logic [7:0] rx_q[$];
    int         start_q[$];

    uart_tx_fifo #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .clr_overrun (clr_overrun),
        .full        (full),
        .empty       (empty),
        .level       (level),
        .busy        (busy),
        .overrun     (overrun),
        .tx_out      (tx_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive at negedge, accepted at the next posedge, returns at the following negedge.
    task automatic push(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        @(negedge clk);
        wr_en   = 1'b0;
        wr_data = 8'hXX;
    endtask

    task automatic wait_frames(input int n);
        int k = 0;
        while (rx_q.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("frame_count", 32'(rx_q.size()), 32'(n));
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(busy == 1'b0 && empty == 1'b1) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic chk_rx(input int idx, input logic [7:0] exp);
        logic [31:0] got;
        got = (idx < rx_q.size()) ? 32'(rx_q[idx]) : 32'hDEAD;
        check($sformatf("rx_byte[%0d]", idx), got, 32'(exp));
    endtask

    // Line monitor: decode 8N1 frames by sampling mid-bit.
    initial begin
        logic       prev;
        logic [7:0] b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !tx_out) begin
                start_q.push_back(cyc);
                repeat (5) @(negedge clk);
                check("start_bit", 32'(tx_out), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = tx_out;
                end
                repeat (10) @(negedge clk);
                check("stop_bit", 32'(tx_out), 32'd1);
                rx_q.push_back(b);
            end
            prev = tx_out;
        end
    end

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        reset_n     = 1'b0;
        wr_data     = 8'h00;
        wr_en       = 1'b0;
        clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx",      32'(tx_out),  32'd1);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_empty",   32'(empty),   32'd1);
        check("rst_full",    32'(full),    32'd0);
        check("rst_level",   32'(level),   32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset mid-frame: 3C sends 0,0 for bits 0,1; cycle 30 is inside bit1 (low).
        push(8'h3C);
        repeat (29) @(negedge clk);
        check("mid_busy", 32'(busy),   32'd1);
        check("mid_tx",   32'(tx_out), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check("async_tx",    32'(tx_out), 32'd1);
        check("async_busy",  32'(busy),   32'd0);
        check("async_empty", 32'(empty),  32'd1);
        check("async_level", 32'(level),  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;

        // Single frame A5 from idle
        push(8'hA5);
        c0 = cyc;
        check("a5_level", 32'(level), 32'd1);
        check("a5_empty", 32'(empty), 32'd0);
        wait_frames(1);
        chk_rx(0, 8'hA5);
        check("a5_latency", 32'(start_q[0]), 32'(c0 + 1));
        repeat (6) @(negedge clk);
        check("a5_busy_drop", 32'(busy),   32'd0);
        check("a5_tx_idle",   32'(tx_out), 32'd1);

        // Three back-to-back frames
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        wait_frames(4);
        chk_rx(1, 8'h00);
        chk_rx(2, 8'hFF);
        chk_rx(3, 8'h55);
        check("b2b_gap0", 32'(start_q[2] - start_q[1]), 32'd100);
        check("b2b_gap1", 32'(start_q[3] - start_q[2]), 32'd100);
        wait_idle();

        // Fill to full while a frame runs, then overflow
        push(8'h11);
        repeat (3) @(negedge clk);
        push(8'h21);
        push(8'h22);
        push(8'h23);
        push(8'h24);
        check("fill_level", 32'(level),   32'd4);
        check("fill_full",  32'(full),    32'd1);
        check("fill_ovr0",  32'(overrun), 32'd0);
        push(8'h25);
        check("ovf_level", 32'(level),   32'd4);
        check("ovf_ovr",   32'(overrun), 32'd1);
        wr_data     = 8'h26;
        wr_en       = 1'b1;
        clr_overrun = 1'b0;
        clr_overrun = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check("set_wins_ovr", 32'(overrun), 32'd1);
        @(negedge clk);
        clr_overrun = 1'b0;
        check("clr_ovr", 32'(overrun), 32'd0);
        wait_frames(9);
        chk_rx(4, 8'h11);
        chk_rx(5, 8'h21);
        chk_rx(6, 8'h22);
        chk_rx(7, 8'h23);
        chk_rx(8, 8'h24);
        wait_idle();
        repeat (50) @(negedge clk);
        check("ovf_frames", 32'(rx_q.size()), 32'd9);

        // Push on the STOP-end pop edge while full: rejected
        push(8'h31);
        c0 = cyc;
        push(8'h32);
        push(8'h33);
        push(8'h34);
        push(8'h35);
        check("p5_full", 32'(full), 32'd1);
        while (cyc < c0 + 100) @(negedge clk);
        check("p5_pre_level", 32'(level), 32'd4);
        push(8'h36);
        check("p5_level", 32'(level),   32'd3);
        check("p5_ovr",   32'(overrun), 32'd1);
        check("p5_full2", 32'(full),    32'd0);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        wait_frames(14);
        for (int i = 0; i < 5; i++) chk_rx(9 + i, 8'h31 + 8'(i));
        check("p5_gap", 32'(start_q[10] - start_q[9]), 32'd100);
        wait_idle();
        repeat (20) @(negedge clk);
        check("p5_frames", 32'(rx_q.size()), 32'd14);

        // Push and pop on the same edge with level 2
        push(8'h41);
        c0 = cyc;
        push(8'h42);
        push(8'h43);
        check("pp_pre_level", 32'(level), 32'd2);
        while (cyc < c0 + 100) @(negedge clk);
        check("pp_mid_level", 32'(level), 32'd2);
        push(8'h44);
        check("pp_level", 32'(level), 32'd2);
        wait_frames(18);
        chk_rx(14, 8'h41);
        chk_rx(15, 8'h42);
        chk_rx(16, 8'h43);
        chk_rx(17, 8'h44);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
